// File: rtl/daq_adc_reader_if.sv
// Sample stream from the ADC reader toward the capture FIFO.
// Each word carries its channel index and start/end-of-frame markers.
interface daq_adc_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHAN_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] sample_o;
  logic [CHAN_WIDTH-1:0] chan_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output sample_o, chan_o, sof_o, eof_o, valid_o,
    input  ready_i
  );

  modport slave (
    input  sample_o, chan_o, sof_o, eof_o, valid_o,
    output ready_i
  );
endinterface

// File: rtl/daq_adc_reader.sv
// Reads one frame of NUM_CHANNELS words from a parallel ADC after each busy fall.
// Each word is streamed out with valid/ready, and overlapping conversions are flagged.
module daq_adc_reader #(
  parameter int NUM_CHANNELS   = 8,
  parameter int CHAN_WIDTH     = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int RD_LOW_CYCLES  = 3,
  parameter int RD_HIGH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  busy_i,
  input  logic [DATA_WIDTH-1:0] db_i,
  output logic                  cs_n_o,
  output logic                  rd_n_o,
  output logic                  overrun_o,
  output logic [15:0]           frame_count_o,
  daq_adc_reader_if.master      smp
);

  localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]      LOW_LAST  = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HIGH_LAST = CNT_W'(RD_HIGH_CYCLES - 1);
  localparam logic [CHAN_WIDTH-1:0] LAST_IDX  = CHAN_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, RD_LOW, RD_HIGH, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d, busy_prev_q, busy_prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CHAN_WIDTH-1:0]   idx_q, idx_d;
  logic                    cs_n_q, cs_n_d, rd_n_q, rd_n_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic [CHAN_WIDTH-1:0]   chan_q, chan_d;
  logic                    sof_q, sof_d, eof_q, eof_d, valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    fall_s, xfer_s;

  assign fall_s = busy_prev_q & ~sync2_q;
  assign xfer_s = valid_q & smp.ready_i;

  // Next-state logic: synchronizer, read sequencer, output register and status.
  always_comb begin
    state_d       = state_q;
    sync1_d       = busy_i;
    sync2_d       = sync1_q;
    busy_prev_d   = sync2_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    cs_n_d        = cs_n_q;
    rd_n_d        = rd_n_q;
    sample_d      = sample_q;
    chan_d        = chan_q;
    sof_d         = sof_q;
    eof_d         = eof_q;
    frame_count_d = frame_count_q;

    if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A conversion finishing mid-frame is only recorded, never serviced.
    if (fall_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (!en_i) begin
          overrun_d = 1'b0;
        end else if (fall_s) begin
          state_d = RD_LOW;
          cs_n_d  = 1'b0;
          rd_n_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_LOW: begin
        if (cnt_q == LOW_LAST) begin
          sample_d = db_i;
          chan_d   = idx_q;
          sof_d    = (idx_q == '0);
          eof_d    = (idx_q == LAST_IDX);
          valid_d  = 1'b1;
          rd_n_d   = 1'b1;
          cnt_d    = '0;
          state_d  = RD_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HIGH: begin
        // The output register must be free before the next strobe begins.
        if (cnt_q != HIGH_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!valid_q || xfer_s) begin
          if (idx_q == LAST_IDX) begin
            cs_n_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            idx_d   = idx_q + CHAN_WIDTH'(1);
            rd_n_d  = 1'b0;
            cnt_d   = '0;
            state_d = RD_LOW;
          end
        end else begin
          state_d = RD_HIGH;
        end
      end
      DRAIN: begin
        if (!valid_q || xfer_s) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        rd_n_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      busy_prev_q   <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      sample_q      <= '0;
      chan_q        <= '0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      busy_prev_q   <= busy_prev_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      cs_n_q        <= cs_n_d;
      rd_n_q        <= rd_n_d;
      sample_q      <= sample_d;
      chan_q        <= chan_d;
      sof_q         <= sof_d;
      eof_q         <= eof_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign cs_n_o        = cs_n_q;
  assign rd_n_o        = rd_n_q;
  assign overrun_o     = overrun_q;
  assign frame_count_o = frame_count_q;
  assign smp.sample_o  = sample_q;
  assign smp.chan_o    = chan_q;
  assign smp.sof_o     = sof_q;
  assign smp.eof_o     = eof_q;
  assign smp.valid_o   = valid_q;

endmodule

// File: doc/daq_adc_reader.md
Name: daq_adc_reader

Overview:
- Downstream companion of the DAQ conversion-trigger stage.
- Watches the ADC busy_i line; when a conversion finishes (busy falls), reads NUM_CHANNELS parallel words from the ADC using cs_n/rd_n strobes.
- Each word goes out on a valid/ready sample stream, tagged with channel index and frame markers, toward the capture FIFO.
- Flags conversions that complete while a previous frame is still being read.

Parameters:
- NUM_CHANNELS, 8: words read per conversion frame; 1..2**CHAN_WIDTH.
- CHAN_WIDTH, 3: width of chan_o.
- DATA_WIDTH, 16: ADC data bus width.
- RD_LOW_CYCLES, 3: clk cycles rd_n_o is held low per word; >=1.
- RD_HIGH_CYCLES, 2: minimum clk cycles rd_n_o is held high between words; >=1.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- en_i  in  1  enable; gates the start of new frames only
- busy_i  in  1  ADC busy, asynchronous to clk_i
- db_i  in  DATA_WIDTH  ADC parallel data bus
- cs_n_o  out  1  ADC chip select, active low
- rd_n_o  out  1  ADC read strobe, active low
- sample_o  out  DATA_WIDTH  captured word
- chan_o  out  CHAN_WIDTH  channel index of sample_o, 0..NUM_CHANNELS-1
- sof_o  out  1  high with channel 0 word
- eof_o  out  1  high with channel NUM_CHANNELS-1 word
- valid_o  out  1  output word valid
- ready_i  in  1  downstream accepts
- overrun_o  out  1  sticky: conversion completed while a frame was in progress
- frame_count_o  out  16  completed frames, wrapping

Behaviour:
- Reset (synchronous, reset_i=1 at a clk_i edge):
  - cs_n_o=1, rd_n_o=1, valid_o=0, sof_o=0, eof_o=0, sample_o=0, chan_o=0, overrun_o=0, frame_count_o=0.
  - State IDLE; synchronizer flops loaded with 1.
  - Reset mid-frame aborts immediately; no partial-frame bookkeeping.
- busy_i passes through a 2-flop synchronizer, then a registered copy. Fall event = previous synced value 1 and current synced value 0.
- Output register holds one word. sample_o, chan_o, sof_o and eof_o are stable while valid_o=1 and ready_i=0. A transfer occurs on any edge with valid_o=1 and ready_i=1.
- States:
  - IDLE:
    - fall event with en_i=1 -> RD_LOW.
    - On that edge: cs_n_o<=0, rd_n_o<=0, word index=0.
    - fall event with en_i=0 is ignored; no overrun is flagged.
  - RD_LOW:
    - rd_n_o held low for exactly RD_LOW_CYCLES cycles.
    - On the edge ending the last low cycle: sample_o<=db_i, chan_o<=index, sof_o<=(index==0), eof_o<=(index==NUM_CHANNELS-1), valid_o<=1, rd_n_o<=1.
    - Next state: RD_HIGH.
  - RD_HIGH:
    - rd_n_o high for at least RD_HIGH_CYCLES cycles.
    - Leaves only when the high count is done AND (valid_o=0 OR a transfer occurs this edge).
    - Not last word: index+1, rd_n_o<=0 -> RD_LOW.
    - Last word: cs_n_o<=1 -> DRAIN.
  - DRAIN:
    - Waits for the final word's transfer.
    - On that edge: frame_count_o+1 (wraps 0xFFFF->0) -> IDLE.
    - If the transfer already happened, exits on the next edge.
- Backpressure never lets RD_LOW start while valid_o=1 without a same-edge transfer. No word is ever overwritten.
- valid_o falls on a transfer edge unless a new capture occurs on the same edge. Same-edge capture is impossible by construction, because RD_HIGH_CYCLES>=1.
- Overrun:
  - A fall event in any state other than IDLE sets overrun_o=1; that event is otherwise ignored.
  - overrun_o clears only by reset_i, or by en_i=0 while in IDLE.
- en_i=0 mid-frame: the current frame completes normally.
- Latency: fall event edge T -> rd_n_o low from T -> first valid_o at edge T+RD_LOW_CYCLES.
- With ready_i held 1, each word takes RD_LOW_CYCLES+RD_HIGH_CYCLES cycles. The frame takes NUM_CHANNELS*(RD_LOW_CYCLES+RD_HIGH_CYCLES)+1 cycles from T to IDLE.

Test Plan:
- Reset, en_i=1, busy_i pulse 1->0, db_i=0x1000+index per word, ready_i=1 -> 8 words 0x1000..0x1007 with chan_o 0..7. sof_o on chan 0, eof_o on chan 7. rd_n_o low exactly 3 cycles per word, high >=2. cs_n_o low spanning all reads. frame_count_o=1.
- Same frame with ready_i=0 for 20 cycles after the first valid_o -> sample_o=0x1000 held stable. rd_n_o stays high. Resumes after ready_i=1; no words lost or duplicated.
- Second busy fall during word 4 of a frame -> overrun_o=1. Current frame completes with 8 words. No extra frame; frame_count_o=1.
- en_i=0 with a busy fall in IDLE -> no strobes, valid_o stays 0. en_i dropped mid-frame -> frame finishes.
- reset_i=1 during RD_LOW of word 2 -> next edge: cs_n_o=1, rd_n_o=1, valid_o=0. Next busy fall starts a clean frame at chan 0.
- Preload frame_count_o to 0xFFFF via 65535 frames (or force) -> next frame wraps it to 0x0000.
